seq_controller: RTL and testbench
=================================

# seq_controller

Parametrised multi-cycle instruction sequencer for the simple microprocessor; drop-in successor to the fixed four-phase controller. It adds a memory-ready handshake with timeout, configurable multiply latency, a true halt state with resume, sticky fault reporting and an optional conditional branch. It drives the same program counter, instruction register, register file, ALU, RAM and mux control signals.

## Interface
- OPCODE_WIDTH, 4: opcode width; encodings DONE, LOAD_M, LOAD_I, LOAD_PC, STORE, ADD, SUB, MUL come from the shared parameters include.
- MUL_LATENCY, 2: extra cycles Alu_Mul is held before write-back; 0 is legal.
- MEM_TIMEOUT, 16: consecutive Mem_Ready-low cycles tolerated; 0 disables the timeout.
- JZ_OPCODE, 4'hF: branch-if-zero encoding; used only with BRANCH_Z_EN.
- Clk  in  1  clock; all transitions occur on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Opcode  in  OPCODE_WIDTH  instruction register opcode field; valid from EXECUTE onward.
- Mem_Ready  in  1  RAM has completed the requested read or write this cycle.
- Resume  in  1  leave HALT.
- Zero  in  1  ALU zero flag; port present only with BRANCH_Z_EN.
- PC_Clr, PC_Load, PC_Inc, IR_Load, Reg_Load  out  1 each  datapath controls.
- Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass  out  1 each  ALU function selects.
- Ram_Data_Read, Ram_Data_Write, Ram_Inst_Read, Load_M, Load_I  out  1 each  memory and mux controls.
- Halted  out  1  state is HALT.
- Instr_Done  out  1  state is RETIRE.
- Fault  out  1  sticky fault flag.
- Fault_Cause  out  2  01 = illegal opcode, 10 = memory timeout; sticky.

## Operation
- Moore outputs are decoded from the state register and the latched opcode Op_Q. Op_Q captures Opcode on the edge leaving EXECUTE.
- States:
  - RESET
    - Asserts PC_Clr.
    - Goes to FETCH on the first edge with Reset low.
  - FETCH
    - Asserts Ram_Inst_Read.
    - Mem_Ready=1 goes to DECODE; otherwise stays.
  - DECODE
    - Asserts IR_Load for one cycle, then goes to EXECUTE.
  - EXECUTE
    - One cycle. Asserts the function signals of Opcode: LOAD_I→Load_I; ADD/SUB/MUL→Alu_*; LOAD_M→Load_M+Ram_Data_Read; STORE→Load_M+Alu_Pass+Ram_Data_Write.
    - Next state: LOAD_M/STORE→MEM_WAIT; MUL→MUL_WAIT if MUL_LATENCY>0, else RETIRE; DONE→HALT; LOAD_I/ADD/SUB/LOAD_PC/JZ→RETIRE.
    - Illegal opcode goes to RESET with Fault=1 and Fault_Cause=01.
  - MEM_WAIT
    - Holds the EXECUTE signals.
    - Mem_Ready=1 goes to RETIRE.
  - MUL_WAIT
    - Holds Alu_Mul for exactly MUL_LATENCY cycles, then goes to RETIRE.
  - HALT
    - All controls 0; Halted=1.
    - Resume=1 goes to RETIRE.
  - RETIRE
    - Single write-back cycle; always returns to FETCH.
    - LOAD_I/ADD/SUB/MUL/LOAD_M: the function signals of Op_Q plus Reg_Load and PC_Inc.
    - STORE: Load_M and Alu_Pass plus PC_Inc; Ram_Data_Write is low.
    - LOAD_PC and taken JZ: PC_Load only.
    - DONE and not-taken JZ: PC_Inc only.
- PC_Load and PC_Inc are never asserted together.
- Timeout counter:
  - Counts consecutive Mem_Ready-low cycles in FETCH and MEM_WAIT, saturating.
  - Clears on Mem_Ready=1 and on any state change.
  - When it reaches MEM_TIMEOUT (non-zero), the next state is RESET with Fault=1 and Fault_Cause=10.
- Fault and Fault_Cause clear only on Reset. A later fault overwrites Fault_Cause.
- Fault recovery re-enters RESET, so PC_Clr is asserted and execution restarts at address 0.

## Timing
- Reset asserted, mid-instruction or not:
  - State goes to RESET immediately (asynchronous).
  - Op_Q, counters, Fault and Fault_Cause clear.
  - Outputs settle to PC_Clr=1 and all others 0.
- Reset deassert: RESET is held for one further edge, then FETCH.
- Latency with zero-wait memory (FETCH through RETIRE inclusive):
  - LOAD_I/ADD/SUB/LOAD_PC/JZ: 4 cycles.
  - LOAD_M/STORE: 5 cycles.
  - MUL: 4+MUL_LATENCY cycles.
- Each Mem_Ready-low cycle adds 1 cycle.
- Mem_Ready is sampled only in FETCH and MEM_WAIT; in other states it is ignored.
- Resume outside HALT is ignored. Resume high on the HALT entry edge is not seen; HALT lasts at least 1 cycle.

## Configuration
- BRANCH_Z_EN
  - Defined: the Zero port exists and JZ_OPCODE is legal. Zero is sampled in EXECUTE and latched with Op_Q. Zero=1 means taken (PC_Load); Zero=0 means not taken (PC_Inc).
  - Undefined: no Zero port. JZ_OPCODE is an illegal opcode: fault 01 and return to RESET.

## Test plan
- Reset mid-MUL_WAIT, Reset=1 for 2 cycles → PC_Clr=1 the same cycle and Fault=0; FETCH on the second edge after release.
- ADD with Mem_Ready=1 → IR_Load in cycle 2, Alu_Add in cycles 3-4, Reg_Load+PC_Inc in cycle 4 only, Instr_Done for 1 cycle.
- MUL with MUL_LATENCY=3 → Alu_Mul high for 5 consecutive cycles, Reg_Load in the last one; total 7 cycles.
- LOAD_M with Mem_Ready low for 2 MEM_WAIT cycles, MEM_TIMEOUT=16 → Ram_Data_Read high 4 cycles, then RETIRE.
  - Same instruction with Mem_Ready held low 16 cycles → RESET, Fault=1, Fault_Cause=10.
- DONE → Halted stays 1 for 10 cycles with all controls 0; Resume=1 → RETIRE with PC_Inc=1, then FETCH.
- JZ_OPCODE:
  - With BRANCH_Z_EN: Zero=1 gives PC_Load=1, PC_Inc=0; Zero=0 gives PC_Inc=1.
  - Without BRANCH_Z_EN: Fault_Cause=01 and PC_Clr asserted.

Source files
------------

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle instruction sequencer for the simple microprocessor.
// Walks FETCH -> DECODE -> EXECUTE -> (MEM_WAIT | MUL_WAIT | HALT) -> RETIRE, with a
// memory-ready timeout, configurable multiply latency and sticky fault reporting.
// Optional feature: define BRANCH_Z_EN to add the Zero port and make JZ_OPCODE a
// legal branch-if-zero instruction; without it JZ_OPCODE raises an illegal-opcode fault.
// Opcode encodings mirror the shared processor parameters.
module seq_controller #(
    parameter int                      OPCODE_WIDTH = 4,
    parameter int                      MUL_LATENCY  = 2,
    parameter int                      MEM_TIMEOUT  = 16,
    parameter logic [OPCODE_WIDTH-1:0] JZ_OPCODE    = 4'hF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [OPCODE_WIDTH-1:0] Opcode,
    input  logic                    Mem_Ready,
    input  logic                    Resume,
`ifdef BRANCH_Z_EN
    input  logic                    Zero,
`endif
    output logic                    PC_Clr,
    output logic                    PC_Load,
    output logic                    PC_Inc,
    output logic                    IR_Load,
    output logic                    Reg_Load,
    output logic                    Alu_Add,
    output logic                    Alu_Sub,
    output logic                    Alu_Mul,
    output logic                    Alu_Pass,
    output logic                    Ram_Data_Read,
    output logic                    Ram_Data_Write,
    output logic                    Ram_Inst_Read,
    output logic                    Load_M,
    output logic                    Load_I,
    output logic                    Halted,
    output logic                    Instr_Done,
    output logic                    Fault,
    output logic [1:0]              Fault_Cause
);

    localparam logic [OPCODE_WIDTH-1:0] OP_DONE    = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD_M  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD_I  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD_PC = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE   = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD     = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB     = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL     = OPCODE_WIDTH'(7);

    localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int MUL_W = (MUL_LATENCY < 2) ? 1 : $clog2(MUL_LATENCY);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXECUTE, S_MEM_WAIT, S_MUL_WAIT, S_HALT, S_RETIRE
    } state_t;

    state_t                  state;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [OPCODE_WIDTH-1:0] op_sel;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [TMO_W-1:0]        tmo_next;
    logic [MUL_W-1:0]        mul_cnt;
    logic                    tmo_hit;
    logic                    mul_done;
`ifdef BRANCH_Z_EN
    logic                    z_q;
`endif

    // Legal opcodes; JZ_OPCODE is accepted only when the branch feature is built in.
    function automatic logic op_legal(input logic [OPCODE_WIDTH-1:0] op);
        case (op)
            OP_DONE, OP_LOAD_M, OP_LOAD_I, OP_LOAD_PC,
            OP_STORE, OP_ADD, OP_SUB, OP_MUL: op_legal = 1'b1;
`ifdef BRANCH_Z_EN
            JZ_OPCODE: op_legal = 1'b1;
`else
            JZ_OPCODE: op_legal = 1'b0;
`endif
            default: op_legal = 1'b0;
        endcase
    endfunction

    // The current Mem_Ready-low cycle is the one that reaches the timeout limit.
    assign tmo_hit  = (MEM_TIMEOUT != 0) && ((int'(tmo_cnt) + 1) >= MEM_TIMEOUT);
    assign tmo_next = (&tmo_cnt) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    assign mul_done = (int'(mul_cnt) >= (MUL_LATENCY - 1));

    // Sequencer state, latched opcode, wait counters and sticky fault status.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_RESET;
            op_q        <= '0;
            tmo_cnt     <= '0;
            mul_cnt     <= '0;
            Fault       <= 1'b0;
            Fault_Cause <= 2'b00;
`ifdef BRANCH_Z_EN
            z_q         <= 1'b0;
`endif
        end else begin
            case (state)
                S_RESET: begin
                    tmo_cnt <= '0;
                    state   <= S_FETCH;
                end
                S_FETCH: begin
                    if (Mem_Ready) begin
                        tmo_cnt <= '0;
                        state   <= S_DECODE;
                    end else if (tmo_hit) begin
                        tmo_cnt     <= '0;
                        Fault       <= 1'b1;
                        Fault_Cause <= 2'b10;
                        state       <= S_RESET;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                S_DECODE: state <= S_EXECUTE;
                S_EXECUTE: begin
                    op_q    <= Opcode;
`ifdef BRANCH_Z_EN
                    z_q     <= Zero;
`endif
                    tmo_cnt <= '0;
                    mul_cnt <= '0;
                    if (!op_legal(Opcode)) begin
                        Fault       <= 1'b1;
                        Fault_Cause <= 2'b01;
                        state       <= S_RESET;
                    end else begin
                        case (Opcode)
                            OP_LOAD_M, OP_STORE: state <= S_MEM_WAIT;
                            OP_MUL:  state <= (MUL_LATENCY > 0) ? S_MUL_WAIT : S_RETIRE;
                            OP_DONE: state <= S_HALT;
                            default: state <= S_RETIRE;
                        endcase
                    end
                end
                S_MEM_WAIT: begin
                    if (Mem_Ready) begin
                        tmo_cnt <= '0;
                        state   <= S_RETIRE;
                    end else if (tmo_hit) begin
                        tmo_cnt     <= '0;
                        Fault       <= 1'b1;
                        Fault_Cause <= 2'b10;
                        state       <= S_RESET;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                S_MUL_WAIT: begin
                    if (mul_done) begin
                        mul_cnt <= '0;
                        state   <= S_RETIRE;
                    end else begin
                        mul_cnt <= mul_cnt + MUL_W'(1);
                    end
                end
                S_HALT: if (Resume) state <= S_RETIRE;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the control word from the state and the instruction's opcode.
    always_comb begin
        PC_Clr = 1'b0; PC_Load = 1'b0; PC_Inc = 1'b0; IR_Load = 1'b0; Reg_Load = 1'b0;
        Alu_Add = 1'b0; Alu_Sub = 1'b0; Alu_Mul = 1'b0; Alu_Pass = 1'b0;
        Ram_Data_Read = 1'b0; Ram_Data_Write = 1'b0; Ram_Inst_Read = 1'b0;
        Load_M = 1'b0; Load_I = 1'b0; Halted = 1'b0; Instr_Done = 1'b0;
        op_sel = (state == S_EXECUTE) ? Opcode : op_q;
        case (state)
            S_RESET:  PC_Clr = 1'b1;
            S_FETCH:  Ram_Inst_Read = 1'b1;
            S_DECODE: IR_Load = 1'b1;
            S_EXECUTE, S_MEM_WAIT, S_MUL_WAIT: begin
                case (op_sel)
                    OP_LOAD_I: Load_I = 1'b1;
                    OP_ADD:    Alu_Add = 1'b1;
                    OP_SUB:    Alu_Sub = 1'b1;
                    OP_MUL:    Alu_Mul = 1'b1;
                    OP_LOAD_M: begin Load_M = 1'b1; Ram_Data_Read = 1'b1; end
                    OP_STORE:  begin Load_M = 1'b1; Alu_Pass = 1'b1; Ram_Data_Write = 1'b1; end
                    default: ;
                endcase
            end
            S_HALT: Halted = 1'b1;
            default: begin
                // Write-back: RAM strobes are dropped, PC moves exactly one way.
                Instr_Done = 1'b1;
                case (op_q)
                    OP_LOAD_I: begin Load_I = 1'b1; Reg_Load = 1'b1; PC_Inc = 1'b1; end
                    OP_ADD:    begin Alu_Add = 1'b1; Reg_Load = 1'b1; PC_Inc = 1'b1; end
                    OP_SUB:    begin Alu_Sub = 1'b1; Reg_Load = 1'b1; PC_Inc = 1'b1; end
                    OP_MUL:    begin Alu_Mul = 1'b1; Reg_Load = 1'b1; PC_Inc = 1'b1; end
                    OP_LOAD_M: begin Load_M = 1'b1; Reg_Load = 1'b1; PC_Inc = 1'b1; end
                    OP_STORE:  begin Load_M = 1'b1; Alu_Pass = 1'b1; PC_Inc = 1'b1; end
                    OP_LOAD_PC: PC_Load = 1'b1;
`ifdef BRANCH_Z_EN
                    JZ_OPCODE: begin
                        if (z_q) PC_Load = 1'b1;
                        else     PC_Inc  = 1'b1;
                    end
`endif
                    default: PC_Inc = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_seq_controller.sv
// Testbench for seq_controller (MUL_LATENCY=3, MEM_TIMEOUT=16).
// A table of per-cycle {inputs, expected control word} records is built up front,
// then applied one record per clock; expected words go through a scoreboard queue
// and are compared on the falling edge.
module tb_seq_controller;

    localparam logic [3:0] OP_DONE    = 4'h0;
    localparam logic [3:0] OP_LOAD_M  = 4'h1;
    localparam logic [3:0] OP_LOAD_I  = 4'h2;
    localparam logic [3:0] OP_LOAD_PC = 4'h3;
    localparam logic [3:0] OP_STORE   = 4'h4;
    localparam logic [3:0] OP_ADD     = 4'h5;
    localparam logic [3:0] OP_SUB     = 4'h6;
    localparam logic [3:0] OP_MUL     = 4'h7;
    localparam logic [3:0] OP_JZ      = 4'hF;
`ifdef BRANCH_Z_EN
    localparam logic [3:0] OP_ILL     = 4'h9;
`else
    localparam logic [3:0] OP_ILL     = OP_JZ;
`endif

    // Control word bit positions, MSB first in the same order as the act vector.
    localparam logic [18:0] E_NONE  = 19'h0;
    localparam logic [18:0] E_PCCLR = 19'h40000;
    localparam logic [18:0] E_PCLD  = 19'h20000;
    localparam logic [18:0] E_PCINC = 19'h10000;
    localparam logic [18:0] E_IRL   = 19'h08000;
    localparam logic [18:0] E_REG   = 19'h04000;
    localparam logic [18:0] E_ADD   = 19'h02000;
    localparam logic [18:0] E_SUB   = 19'h01000;
    localparam logic [18:0] E_MUL   = 19'h00800;
    localparam logic [18:0] E_PASS  = 19'h00400;
    localparam logic [18:0] E_RDR   = 19'h00200;
    localparam logic [18:0] E_RDW   = 19'h00100;
    localparam logic [18:0] E_RIR   = 19'h00080;
    localparam logic [18:0] E_LM    = 19'h00040;
    localparam logic [18:0] E_LI    = 19'h00020;
    localparam logic [18:0] E_HALT  = 19'h00010;
    localparam logic [18:0] E_DONE  = 19'h00008;
    localparam logic [18:0] E_TMO   = 19'h00006;
    localparam logic [18:0] E_ILL   = 19'h00005;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        rdy;
        logic        res;
        logic        z;
        logic [18:0] exp;
        string       tag;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       resume;
`ifdef BRANCH_Z_EN
    logic       zero;
`endif
    logic pc_clr, pc_load, pc_inc, ir_load, reg_load;
    logic alu_add, alu_sub, alu_mul, alu_pass;
    logic ram_data_read, ram_data_write, ram_inst_read, load_m, load_i;
    logic halted, instr_done, fault;
    logic [1:0] fault_cause;
    logic [18:0] act;

    vec_t        vecs[$];
    logic [18:0] exp_q[$];
    string       tag_q[$];
    logic [18:0] flt;
    logic        cur_z;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [18:0] mon_e;
    string       mon_t;

    seq_controller #(
        .OPCODE_WIDTH(4),
        .MUL_LATENCY (3),
        .MEM_TIMEOUT (16),
        .JZ_OPCODE   (4'hF)
    ) dut (
        .Clk           (clk),
        .Reset         (reset),
        .Opcode        (opcode),
        .Mem_Ready     (mem_ready),
        .Resume        (resume),
`ifdef BRANCH_Z_EN
        .Zero          (zero),
`endif
        .PC_Clr        (pc_clr),
        .PC_Load       (pc_load),
        .PC_Inc        (pc_inc),
        .IR_Load       (ir_load),
        .Reg_Load      (reg_load),
        .Alu_Add       (alu_add),
        .Alu_Sub       (alu_sub),
        .Alu_Mul       (alu_mul),
        .Alu_Pass      (alu_pass),
        .Ram_Data_Read (ram_data_read),
        .Ram_Data_Write(ram_data_write),
        .Ram_Inst_Read (ram_inst_read),
        .Load_M        (load_m),
        .Load_I        (load_i),
        .Halted        (halted),
        .Instr_Done    (instr_done),
        .Fault         (fault),
        .Fault_Cause   (fault_cause)
    );

    assign act = {pc_clr, pc_load, pc_inc, ir_load, reg_load, alu_add, alu_sub, alu_mul,
                  alu_pass, ram_data_read, ram_data_write, ram_inst_read, load_m, load_i,
                  halted, instr_done, fault, fault_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table record = the inputs held for one cycle and the control word during it.
    task automatic add(input logic rst, input logic [3:0] op, input logic rdy,
                       input logic res, input logic [18:0] e, input string tag);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.res = res; v.z = cur_z;
        v.exp = e | flt; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic fd(input logic [3:0] op, input string tag);
        add(1'b0, op, 1'b1, 1'b0, E_RIR, {tag, "_fetch"});
        add(1'b0, op, 1'b0, 1'b0, E_IRL, {tag, "_decode"});
    endtask

    // Scoreboard check, away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            n_cmp++;
            if (act !== mon_e) begin
                n_bad++;
                $display("FAIL %s: control word %b, required %b", mon_t, act, mon_e);
            end
        end
    end

    initial begin
        reset = 1'b1; opcode = OP_DONE; mem_ready = 1'b0; resume = 1'b0;
`ifdef BRANCH_Z_EN
        zero = 1'b0;
`endif
        flt = E_NONE; cur_z = 1'b0;

        // Reset and release.
        add(1'b1, OP_DONE, 1'b0, 1'b0, E_PCCLR, "reset");
        add(1'b1, OP_DONE, 1'b1, 1'b1, E_PCCLR, "reset_hold");
        add(1'b0, OP_DONE, 1'b0, 1'b0, E_PCCLR, "reset_release");

        // ADD, zero-wait: 4 cycles.
        fd(OP_ADD, "add");
        add(1'b0, OP_ADD, 1'b0, 1'b0, E_ADD, "add_exec");
        add(1'b0, OP_ADD, 1'b0, 1'b0, E_ADD | E_REG | E_PCINC | E_DONE, "add_retire");

        // SUB with one FETCH wait cycle; Resume outside HALT ignored.
        add(1'b0, OP_SUB, 1'b0, 1'b1, E_RIR, "sub_fetch_wait");
        fd(OP_SUB, "sub");
        add(1'b0, OP_SUB, 1'b1, 1'b1, E_SUB, "sub_exec");
        add(1'b0, OP_SUB, 1'b0, 1'b0, E_SUB | E_REG | E_PCINC | E_DONE, "sub_retire");

        // LOAD_I and LOAD_PC.
        fd(OP_LOAD_I, "loadi");
        add(1'b0, OP_LOAD_I, 1'b0, 1'b0, E_LI, "loadi_exec");
        add(1'b0, OP_ADD, 1'b0, 1'b0, E_LI | E_REG | E_PCINC | E_DONE, "loadi_retire");
        fd(OP_LOAD_PC, "loadpc");
        add(1'b0, OP_LOAD_PC, 1'b0, 1'b0, E_NONE, "loadpc_exec");
        add(1'b0, OP_LOAD_PC, 1'b0, 1'b0, E_PCLD | E_DONE, "loadpc_retire");

        // MUL with latency 3: Alu_Mul for 5 cycles, 7 in total.
        fd(OP_MUL, "mul");
        add(1'b0, OP_MUL, 1'b0, 1'b0, E_MUL, "mul_exec");
        for (int i = 0; i < 3; i++) add(1'b0, OP_ADD, 1'b1, 1'b0, E_MUL, "mul_wait");
        add(1'b0, OP_ADD, 1'b0, 1'b0, E_MUL | E_REG | E_PCINC | E_DONE, "mul_retire");

        // STORE, zero-wait memory: 5 cycles, no Ram_Data_Write in write-back.
        fd(OP_STORE, "store");
        add(1'b0, OP_STORE, 1'b0, 1'b0, E_LM | E_PASS | E_RDW, "store_exec");
        add(1'b0, OP_STORE, 1'b1, 1'b0, E_LM | E_PASS | E_RDW, "store_memwait");
        add(1'b0, OP_STORE, 1'b0, 1'b0, E_LM | E_PASS | E_PCINC | E_DONE, "store_retire");

        // LOAD_M with two not-ready MEM_WAIT cycles: Ram_Data_Read for 4 cycles.
        fd(OP_LOAD_M, "loadm");
        add(1'b0, OP_LOAD_M, 1'b1, 1'b0, E_LM | E_RDR, "loadm_exec");
        add(1'b0, OP_LOAD_M, 1'b0, 1'b0, E_LM | E_RDR, "loadm_wait1");
        add(1'b0, OP_LOAD_M, 1'b0, 1'b0, E_LM | E_RDR, "loadm_wait2");
        add(1'b0, OP_LOAD_M, 1'b1, 1'b0, E_LM | E_RDR, "loadm_ready");
        add(1'b0, OP_LOAD_M, 1'b0, 1'b0, E_LM | E_REG | E_PCINC | E_DONE, "loadm_retire");

        // DONE: Resume on the HALT entry edge is not seen; halt 10 cycles, then resume.
        fd(OP_DONE, "done");
        add(1'b0, OP_DONE, 1'b0, 1'b1, E_NONE, "done_exec");
        for (int i = 0; i < 10; i++) add(1'b0, OP_DONE, 1'b1, 1'b0, E_HALT, "halt");
        add(1'b0, OP_DONE, 1'b0, 1'b1, E_HALT, "halt_resume");
        add(1'b0, OP_DONE, 1'b0, 1'b0, E_PCINC | E_DONE, "done_retire");

`ifdef BRANCH_Z_EN
        // JZ taken and not taken; Zero flips after EXECUTE to show it is latched.
        fd(OP_JZ, "jz_taken");
        cur_z = 1'b1;
        add(1'b0, OP_JZ, 1'b0, 1'b0, E_NONE, "jz_taken_exec");
        cur_z = 1'b0;
        add(1'b0, OP_JZ, 1'b0, 1'b0, E_PCLD | E_DONE, "jz_taken_retire");
        fd(OP_JZ, "jz_not");
        add(1'b0, OP_JZ, 1'b0, 1'b0, E_NONE, "jz_not_exec");
        cur_z = 1'b1;
        add(1'b0, OP_JZ, 1'b0, 1'b0, E_PCINC | E_DONE, "jz_not_retire");
        cur_z = 1'b0;
`endif

        // Reset asserted in MUL_WAIT for two cycles.
        fd(OP_MUL, "mulrst");
        add(1'b0, OP_MUL, 1'b0, 1'b0, E_MUL, "mulrst_exec");
        add(1'b0, OP_MUL, 1'b0, 1'b0, E_MUL, "mulrst_wait");
        add(1'b1, OP_MUL, 1'b0, 1'b0, E_PCCLR, "mulrst_assert");
        add(1'b1, OP_MUL, 1'b1, 1'b0, E_PCCLR, "mulrst_hold");
        add(1'b0, OP_MUL, 1'b1, 1'b0, E_PCCLR, "mulrst_release");

        // LOAD_M with Mem_Ready low for 16 MEM_WAIT cycles: timeout fault.
        fd(OP_LOAD_M, "tmo");
        add(1'b0, OP_LOAD_M, 1'b0, 1'b0, E_LM | E_RDR, "tmo_exec");
        for (int i = 0; i < 16; i++) add(1'b0, OP_LOAD_M, 1'b0, 1'b0, E_LM | E_RDR, "tmo_wait");
        flt = E_TMO;
        add(1'b0, OP_LOAD_M, 1'b0, 1'b0, E_PCCLR, "tmo_reset");

        // Illegal opcode overwrites the fault cause and re-enters RESET.
        fd(OP_ILL, "ill");
        add(1'b0, OP_ILL, 1'b0, 1'b0, E_NONE, "ill_exec");
        flt = E_ILL;
        add(1'b0, OP_ILL, 1'b0, 1'b0, E_PCCLR, "ill_reset");
        add(1'b0, OP_ILL, 1'b0, 1'b0, E_RIR, "ill_refetch");

        // Only Reset clears the sticky fault.
        flt = E_NONE;
        add(1'b1, OP_DONE, 1'b0, 1'b0, E_PCCLR, "fault_clear");

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset     = vecs[i].rst;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].rdy;
            resume    = vecs[i].res;
`ifdef BRANCH_Z_EN
            zero      = vecs[i].z;
`endif
            exp_q.push_back(vecs[i].exp);
            tag_q.push_back(vecs[i].tag);
        end
        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
